// File: rtl/ram_responder.sv
// Word-addressed RAM responder with programmable access latency and ramstate handshake.
// Define RAM_STATS_EN to build the saturating rd_count/wr_count statistics counters.
module ram_responder #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned LAT    = 2
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ramREN,
  input  logic        ramWEN,
  input  logic [31:0] ramaddr,
  input  logic [31:0] ramstore,
  output logic [31:0] ramload,
  output logic [1:0]  ramstate,
  output logic [31:0] rd_count,
  output logic [31:0] wr_count
);

  localparam logic [1:0] FREE   = 2'd0;
  localparam logic [1:0] BUSY   = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] ERROR  = 2'd3;

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned CNT_W = (LAT < 1) ? 1 : $clog2(LAT + 1);
  localparam int unsigned REQ_W = 66;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LAT);
  localparam logic ZERO_LAT = 1'(LAT == 0);

  logic [31:0]       mem [DEPTH];
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_next;
  logic [REQ_W-1:0]  prev_req;
  logic [REQ_W-1:0]  cur_req;
  logic [ADDR_W-1:0] idx;
  logic              req;
  logic              err;
  logic              same;
  logic              access;

  assign cur_req = {ramREN, ramWEN, ramaddr, ramstore};
  assign idx     = ramaddr[ADDR_W+1:2];
  assign req     = ramREN ^ ramWEN;
  assign err     = (ramREN & ramWEN) | ((ramREN | ramWEN) & (ramaddr[1:0] != 2'b00));
  assign same    = (prev_req == cur_req);
  assign access  = req && !err && (same || ZERO_LAT) && (cnt == CNT_MAX);

  // Handshake state seen by the arbiter
  always_comb begin
    ramstate = BUSY;
    if (err) begin
      ramstate = ERROR;
    end else if (!req) begin
      ramstate = FREE;
    end else if (access) begin
      ramstate = ACCESS;
    end
  end

  // Latency counter: the first cycle of a new request already counts toward LAT
  always_comb begin
    cnt_next = '0;
    if (req && !err && !access) begin
      if (!same) begin
        cnt_next = CNT_W'(1);
      end else begin
        cnt_next = cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cnt      <= '0;
      prev_req <= '0;
    end else begin
      cnt      <= cnt_next;
      prev_req <= cur_req;
    end
  end

  // Storage is not reset; a write caught by reset must not commit
  always_ff @(posedge CLK) begin
    if (nRST && access && ramWEN) begin
      mem[idx] <= ramstore;
    end
  end

  assign ramload = (access && ramREN) ? mem[idx] : 32'h0;

`ifdef RAM_STATS_EN
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      rd_count <= '0;
      wr_count <= '0;
    end else if (access) begin
      if (ramREN && (rd_count != 32'hFFFF_FFFF)) begin
        rd_count <= rd_count + 32'd1;
      end
      if (ramWEN && (wr_count != 32'hFFFF_FFFF)) begin
        wr_count <= wr_count + 32'd1;
      end
    end
  end
`else
  assign rd_count = 32'h0;
  assign wr_count = 32'h0;
`endif

endmodule

// File: tb/tb_ram_responder.sv
// Bench for ram_responder: LAT=2 and LAT=0 instances on shared stimulus, checked against a
// cycle-level reference model (held-cycle count modulo LAT+1, word array, completion counts).
module tb_ram_responder;

  localparam int unsigned ADDR_W = 10;
  localparam int unsigned DEPTH  = 1 << ADDR_W;
  localparam logic [1:0] S_FREE   = 2'd0;
  localparam logic [1:0] S_BUSY   = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;
  localparam logic [1:0] S_ERROR  = 2'd3;
`ifdef RAM_STATS_EN
  localparam logic [31:0] STAT_MASK = 32'hFFFF_FFFF;
`else
  localparam logic [31:0] STAT_MASK = 32'h0;
`endif

  logic        CLK = 1'b0;
  logic        nRST;
  logic        ren;
  logic        wen;
  logic [31:0] addr;
  logic [31:0] store;
  logic [31:0] load_o [2];
  logic [1:0]  st_o   [2];
  logic [31:0] rdc_o  [2];
  logic [31:0] wrc_o  [2];

  always #5 CLK = ~CLK;

  ram_responder #(.ADDR_W(ADDR_W), .LAT(2)) u_lat2 (
    .CLK(CLK), .nRST(nRST), .ramREN(ren), .ramWEN(wen), .ramaddr(addr), .ramstore(store),
    .ramload(load_o[0]), .ramstate(st_o[0]), .rd_count(rdc_o[0]), .wr_count(wrc_o[0])
  );

  ram_responder #(.ADDR_W(ADDR_W), .LAT(0)) u_lat0 (
    .CLK(CLK), .nRST(nRST), .ramREN(ren), .ramWEN(wen), .ramaddr(addr), .ramstore(store),
    .ramload(load_o[1]), .ramstate(st_o[1]), .rd_count(rdc_o[1]), .wr_count(wrc_o[1])
  );

  // Reference model
  int unsigned lat [2] = '{2, 0};
  logic [31:0] mdl_mem [2][DEPTH];
  int unsigned held    [2];
  int unsigned held_e  [2];
  logic        acc_e   [2];
  logic [31:0] mrd     [2];
  logic [31:0] mwr     [2];
  logic        p_ren;
  logic        p_wen;
  logic [31:0] p_addr;
  logic [31:0] p_store;
  logic [1:0]  last_st   [2];
  logic [31:0] last_load [2];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    ren = r; wen = w; addr = a; store = d;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      held[i] = 0;
      mrd[i]  = 32'h0;
      mwr[i]  = 32'h0;
    end
    p_ren = 1'b0; p_wen = 1'b0; p_addr = 32'h0; p_store = 32'h0;
  endtask

  // One clock: check outputs at negedge, then advance the model at posedge
  task automatic step(input bit rst_pulse);
    logic bad;
    logic valid;
    logic same;
    logic [1:0] st;
    logic [31:0] ld;
    int unsigned w;
    @(negedge CLK);
    bad   = (ren && wen) || ((ren || wen) && (addr % 4 != 0));
    valid = (ren != wen) && !bad;
    same  = (ren == p_ren) && (wen == p_wen) && (addr == p_addr) && (store == p_store);
    w     = (addr / 4) % DEPTH;
    for (int i = 0; i < 2; i++) begin
      held_e[i] = valid ? (same ? held[i] + 1 : 1) : 0;
      acc_e[i]  = valid && (held_e[i] % (lat[i] + 1) == 0);
      if (bad) st = S_ERROR;
      else if (ren == wen) st = S_FREE;
      else if (acc_e[i]) st = S_ACCESS;
      else st = S_BUSY;
      ld = (acc_e[i] && ren) ? mdl_mem[i][w] : 32'h0;
      last_st[i]   = st_o[i];
      last_load[i] = load_o[i];
      chk($sformatf("state_lat%0d", lat[i]), 32'(st_o[i]), 32'(st));
      chk($sformatf("load_lat%0d", lat[i]), load_o[i], ld);
      chk($sformatf("rd_count_lat%0d", lat[i]), rdc_o[i], mrd[i] & STAT_MASK);
      chk($sformatf("wr_count_lat%0d", lat[i]), wrc_o[i], mwr[i] & STAT_MASK);
    end
    if (rst_pulse) begin
      #1 nRST = 1'b0;
    end
    @(posedge CLK);
    if (rst_pulse) begin
      model_reset();
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (acc_e[i] && wen) mdl_mem[i][w] = store;
        if (acc_e[i] && ren && mrd[i] != 32'hFFFF_FFFF) mrd[i] = mrd[i] + 1;
        if (acc_e[i] && wen && mwr[i] != 32'hFFFF_FFFF) mwr[i] = mwr[i] + 1;
        held[i] = held_e[i];
      end
      p_ren = ren; p_wen = wen; p_addr = addr; p_store = store;
    end
    #1 nRST = 1'b1;
  endtask

  function automatic logic [31:0] rnd_addr();
    logic [31:0] a;
    a = 32'($urandom_range(0, 15)) * 4;
    if ($urandom_range(0, 3) == 0) a = a + (32'($urandom_range(1, 7)) << (ADDR_W + 2));
    if ($urandom_range(0, 9) == 0) a = a + 32'($urandom_range(1, 3));
    return a;
  endfunction

  initial begin
    int unsigned r;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < DEPTH; j++) mdl_mem[i][j] = 32'h0;
    model_reset();
    nRST = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    #23 nRST = 1'b1;

    // Idle after reset
    step(0);
    chk("reset_state", 32'(last_st[0]), 32'(S_FREE));
    chk("reset_load", last_load[0], 32'h0);

    // Write 0x10, expect BUSY, BUSY, ACCESS
    drive(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF);
    step(0); chk("wr_c1", 32'(last_st[0]), 32'(S_BUSY));
    step(0); chk("wr_c2", 32'(last_st[0]), 32'(S_BUSY));
    step(0); chk("wr_c3", 32'(last_st[0]), 32'(S_ACCESS));
    drive(1'b1, 1'b0, 32'h10, 32'h0);
    step(0); step(0);
    step(0); chk("rd_c3", 32'(last_st[0]), 32'(S_ACCESS));
    chk("rd_data", last_load[0], 32'hDEAD_BEEF);
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    step(0);
    chk("wr_count_after", wrc_o[0], 32'd1 & STAT_MASK);
    chk("rd_count_after", rdc_o[0], 32'd1 & STAT_MASK);

    // Source switch mid-latency restarts the count
    drive(1'b1, 1'b0, 32'h20, 32'h0);
    step(0); chk("sw_first", 32'(last_st[0]), 32'(S_BUSY));
    drive(1'b1, 1'b0, 32'h24, 32'h0);
    step(0); chk("sw_c1", 32'(last_st[0]), 32'(S_BUSY));
    step(0); chk("sw_c2", 32'(last_st[0]), 32'(S_BUSY));
    step(0); chk("sw_c3", 32'(last_st[0]), 32'(S_ACCESS));

    // Error cases leave memory and counts alone
    drive(1'b1, 1'b1, 32'h10, 32'h5555_5555);
    step(0); chk("err_both", 32'(last_st[0]), 32'(S_ERROR));
    drive(1'b0, 1'b1, 32'h13, 32'h6666_6666);
    step(0); chk("err_align", 32'(last_st[0]), 32'(S_ERROR));
    step(0); step(0);
    drive(1'b1, 1'b0, 32'h10, 32'h0);
    step(0); step(0); step(0);
    chk("err_mem_kept", last_load[0], 32'hDEAD_BEEF);

    // Reset during BUSY of a write aborts it
    drive(1'b0, 1'b1, 32'h40, 32'h1234);
    step(1);
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    step(0); chk("rst_free", 32'(last_st[0]), 32'(S_FREE));
    chk("rst_rdcnt", rdc_o[0], 32'h0);
    drive(1'b1, 1'b0, 32'h40, 32'h0);
    step(0); chk("rst_lat0_load", last_load[1], 32'h0);
    step(0);
    step(0); chk("rst_lat2_load", last_load[0], 32'h0);

    // Zero latency and address aliasing
    drive(1'b0, 1'b1, 32'h8, 32'hA5);
    step(0); chk("lat0_wr", 32'(last_st[1]), 32'(S_ACCESS));
    drive(1'b1, 1'b0, 32'h8, 32'h0);
    step(0); chk("lat0_rd", 32'(last_st[1]), 32'(S_ACCESS));
    chk("lat0_data", last_load[1], 32'hA5);
    drive(1'b1, 1'b0, 32'h8 + 4 * DEPTH, 32'h0);
    step(0); chk("lat0_alias", last_load[1], 32'hA5);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      r = $urandom_range(0, 99);
      if (r < 55) begin
        // hold current request
      end else if (r < 63) drive(1'b0, 1'b0, 32'h0, 32'h0);
      else if (r < 80) drive(1'b1, 1'b0, rnd_addr(), 32'h0);
      else if (r < 96) drive(1'b0, 1'b1, rnd_addr(), $urandom);
      else drive(1'b1, 1'b1, rnd_addr(), $urandom);
      step($urandom_range(0, 149) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
